axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-master AXI4 read-channel arbiter placed between the core's memory clients and the single SoC read port. Port 0 carries fetch-unit icache line refills. Port 1 carries load/store-unit dcache/uncached reads. Only one burst is outstanding at a time. Port 1 has fixed priority, and a starvation counter guarantees that instruction fetch makes forward progress. Write channels bypass this block.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all AR channels
- DATA_WIDTH, 64, R data width of all ports
- STARVE_MAX, 4, number of consecutive port-1 wins while port 0 waits before port 0 is forced
Ports (m_* vectors: index 0 = fetch, index 1 = load/store; packed buses use slice [i*W +: W]):
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- m_arvalid  in  2  per-master AR valid
- m_arready  out  2  per-master AR ready
- m_araddr  in  2*ADDR_WIDTH  per-master address
- m_arlen  in  2*8  per-master burst length minus one
- m_arsize  in  2*3  per-master beat size
- m_rvalid  out  2  per-master R valid
- m_rready  in  2  per-master R ready
- m_rdata  out  DATA_WIDTH  broadcast R data
- m_rresp  out  2  broadcast R response
- m_rlast  out  1  broadcast R last
- s_arvalid  out  1  downstream AR valid
- s_arready  in  1  downstream AR ready
- s_araddr  out  ADDR_WIDTH  downstream address
- s_arlen  out  8  downstream burst length
- s_arsize  out  3  downstream size
- s_arburst  out  2  constant 2'b01 (INCR)
- s_rvalid  in  1  downstream R valid
- s_rready  out  1  downstream R ready
- s_rdata  in  DATA_WIDTH  downstream data
- s_rresp  in  2  downstream response
- s_rlast  in  1  downstream last
- gnt  out  1  index of the current or last granted master
- prot_err  out  1  one-cycle pulse on a burst-length mismatch

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any m_arvalid is set, register gnt and move to ADDR.
  - Selection: port 1 wins if it is requesting, except when port 0 is requesting and starve_cnt == STARVE_MAX; then port 0 wins.
  - A sole requester always wins.
- starve_cnt, width $clog2(STARVE_MAX+1):
  - increments when a grant goes to port 1 while m_arvalid[0] = 1
  - clears to 0 when port 0 is granted
  - saturates at STARVE_MAX
- ADDR: s_ar* is a combinational pass-through of the granted master; s_arvalid = m_arvalid[gnt]; m_arready[gnt] = s_arready; the other m_arready = 0.
  - On s_arvalid & s_arready: latch arlen into len_q, clear beat_cnt (8 bits), move to DATA.
  - A master that drops arvalid before the handshake violates AXI; the block holds ADDR with no timeout.
- DATA: m_rvalid[gnt] = s_rvalid; s_rready = m_rready[gnt]; the non-granted m_rvalid = 0. rdata, rresp and rlast are broadcast unchanged.
  - Each beat (s_rvalid & s_rready) increments beat_cnt.
  - A beat with s_rlast = 1 moves the FSM to IDLE.
  - prot_err pulses on the cycle after a beat where s_rlast = 1 and beat_cnt != len_q, or where s_rlast = 0 and beat_cnt == len_q. The FSM still waits for s_rlast before leaving DATA.
- gnt never changes outside the IDLE->ADDR transition.

## Timing
- Reset values: state = IDLE, gnt = 0, starve_cnt = 0, len_q = 0, beat_cnt = 0, prot_err = 0.
- Outputs while in IDLE or during reset: s_arvalid = 0, m_arready = 0, m_rvalid = 0, s_rready = 0.
- Grant latency: m_arvalid high in cycle N gives s_arvalid high in cycle N+1. The AR handshake can complete in N+1.
- The first R beat is forwarded combinationally in the same cycle it arrives, with zero added latency.
- The last-beat handshake in cycle M puts the FSM in IDLE at M+1. The next grant is registered at M+1 and s_arvalid asserts at M+2. This gives one bubble cycle between bursts.
- Both masters arriving in the same cycle are resolved by the priority rule, and the loser keeps arvalid asserted.
- Reset asserted mid-burst: next cycle is IDLE with all handshakes low. In-flight beats are dropped; the downstream slave shares the same reset.
- In-flight bursts are never aborted; fetch-redirect flushes are handled by the master.

## Test plan
- Single port 0 request: addr 0x3000_0000, arlen 3 -> s_arvalid at cycle +1 with the same addr/len, s_arburst 2'b01, 4 beats on m_rvalid[0] only, m_rvalid[1] stays 0, IDLE after rlast, prot_err stays 0.
- Simultaneous requests: port 0 0x3000_0040, port 1 0x8000_0010 arlen 0 -> port 1 granted first (gnt = 1); port 0 granted 2 cycles after port 1's rlast.
- Starvation: port 1 requests continuously and port 0 holds arvalid -> after 4 port-1 grants, the 5th grant goes to port 0 and starve_cnt returns to 0.
- Backpressure: m_rready[0] low for 3 cycles mid-burst -> s_rready low in the same cycles, no beat lost or duplicated, beat_cnt is correct.
- Protocol error: arlen 3 with slave rlast on beat 2 -> prot_err is a one-cycle pulse, FSM returns to IDLE.
- Reset during DATA with beat 1 of 4 -> outputs reach their reset values the next cycle, and a new request is granted normally after reset deasserts.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter: one burst in flight, port 1 priority,
// starvation counter forces a fetch grant after STARVE_MAX lost rounds.
module axi_rd_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              m_arvalid,
   output logic [1:0]              m_arready,
   input  logic [2*ADDR_WIDTH-1:0] m_araddr,
   input  logic [15:0]             m_arlen,
   input  logic [5:0]              m_arsize,
   output logic [1:0]              m_rvalid,
   input  logic [1:0]              m_rready,
   output logic [DATA_WIDTH-1:0]   m_rdata,
   output logic [1:0]              m_rresp,
   output logic                    m_rlast,
   output logic                    s_arvalid,
   input  logic                    s_arready,
   output logic [ADDR_WIDTH-1:0]   s_araddr,
   output logic [7:0]              s_arlen,
   output logic [2:0]              s_arsize,
   output logic [1:0]              s_arburst,
   input  logic                    s_rvalid,
   output logic                    s_rready,
   input  logic [DATA_WIDTH-1:0]   s_rdata,
   input  logic [1:0]              s_rresp,
   input  logic                    s_rlast,
   output logic                    gnt,
   output logic                    prot_err
);
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    beat_q, beat_d;
   logic          perr_q, perr_d;
   logic          starved, sel, ar_hs, r_hs;

   assign starved = (starve_q == SW'(STARVE_MAX));
   assign sel     = m_arvalid[1] & ~(m_arvalid[0] & starved);

   assign s_araddr  = gnt_q ? m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                            : m_araddr[ADDR_WIDTH-1:0];
   assign s_arlen   = gnt_q ? m_arlen[15:8] : m_arlen[7:0];
   assign s_arsize  = gnt_q ? m_arsize[5:3] : m_arsize[2:0];
   assign s_arburst = 2'b01;

   assign m_rdata = s_rdata;
   assign m_rresp = s_rresp;
   assign m_rlast = s_rlast;

   assign gnt      = gnt_q;
   assign prot_err = perr_q;

   // Handshakes are held low while reset is asserted, whatever the state.
   always_comb begin
      s_arvalid = 1'b0;
      m_arready = 2'b00;
      m_rvalid  = 2'b00;
      s_rready  = 1'b0;
      if (!reset) begin
         if (state_q == ADDR) begin
            s_arvalid        = m_arvalid[gnt_q];
            m_arready[gnt_q] = s_arready;
         end
         if (state_q == DATA) begin
            m_rvalid[gnt_q] = s_rvalid;
            s_rready        = m_rready[gnt_q];
         end
      end
   end

   assign ar_hs = s_arvalid & s_arready;
   assign r_hs  = s_rvalid & s_rready;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      starve_d = starve_q;
      len_d    = len_q;
      beat_d   = beat_q;
      perr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|m_arvalid) begin
               gnt_d   = sel;
               state_d = ADDR;
               if (!sel)
                  starve_d = '0;
               else if (m_arvalid[0] && !starved)
                  starve_d = starve_q + SW'(1);
            end
         end
         ADDR: begin
            if (ar_hs) begin
               len_d   = s_arlen;
               beat_d  = 8'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (r_hs) begin
               beat_d = beat_q + 8'd1;
               perr_d = s_rlast ^ (beat_q == len_q);
               if (s_rlast)
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         starve_q <= '0;
         len_q    <= 8'd0;
         beat_q   <= 8'd0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         starve_q <= starve_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         perr_q   <= perr_d;
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: random masters and slave,
// grant/beat expectations from a burst-level model of the arbiter.
module tb_axi_rd_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 64;
   localparam int SMAX = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
   logic [2*AW-1:0] m_araddr;
   logic [15:0]     m_arlen;
   logic [5:0]      m_arsize;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic            m_rlast;
   logic            s_arvalid, s_arready;
   logic [AW-1:0]   s_araddr;
   logic [7:0]      s_arlen;
   logic [2:0]      s_arsize;
   logic [1:0]      s_arburst;
   logic            s_rvalid, s_rready;
   logic [DW-1:0]   s_rdata;
   logic [1:0]      s_rresp;
   logic            s_rlast;
   logic            gnt, prot_err;

   axi_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SMAX)) dut (
      .clock(clock), .reset(reset),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rlast(s_rlast),
      .gnt(gnt), .prot_err(prot_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } req_t;

   req_t          rq[2][$];
   logic [DW-1:0] exp_data[$];
   logic          dut_grants[$];

   int total = 0;
   int bad   = 0;

   int gap_pct = 0, rdy_pct = 100, ardy_pct = 100, rv_pct = 100;
   int err_pct = 0, force_beats = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Handshakes seen by the stimulus side, sampled mid-cycle.
   logic [1:0] m_hs = 2'b00;
   logic       s_ar_hs = 1'b0, s_r_hs = 1'b0, rst_seen = 1'b1;
   logic [7:0] ar_len_cap = 8'd0;
   int         perr_cnt = 0;

   always @(negedge clock) begin
      rst_seen   = reset;
      m_hs       = m_arvalid & m_arready;
      s_ar_hs    = s_arvalid & s_arready;
      s_r_hs     = s_rvalid & s_rready;
      ar_len_cap = s_arlen;
      if (prot_err) perr_cnt++;
      if (s_arvalid && s_arready) dut_grants.push_back(gnt);
   end

   // Stimulus: two masters and one slave.
   int remain = 0;
   initial begin
      m_arvalid = 2'b00; m_araddr = '0; m_arlen = '0; m_arsize = '0;
      m_rready = 2'b00; s_arready = 1'b0;
      s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (rst_seen) begin
            m_arvalid = 2'b00;
            s_rvalid  = 1'b0;
            s_rlast   = 1'b0;
            remain    = 0;
            exp_data.delete();
         end else begin
            for (int p = 0; p < 2; p++) begin
               if (m_hs[p]) begin
                  void'(rq[p].pop_front());
                  m_arvalid[p] = 1'b0;
               end
               if (!m_arvalid[p] && rq[p].size() > 0 &&
                   $urandom_range(99) >= gap_pct) begin
                  m_arvalid[p]          = 1'b1;
                  m_araddr[p*AW +: AW]  = rq[p][0].addr;
                  m_arlen[p*8 +: 8]     = rq[p][0].len;
                  m_arsize[p*3 +: 3]    = 3'd3;
               end
            end
            if (s_ar_hs) begin
               remain = int'(ar_len_cap) + 1;
               if (force_beats > 0)
                  remain = force_beats;
               else if ($urandom_range(99) < err_pct) begin
                  if (ar_len_cap > 0 && $urandom_range(1) == 1)
                     remain = int'(ar_len_cap);
                  else
                     remain = int'(ar_len_cap) + 2;
               end
            end
            if (s_r_hs) begin
               s_rvalid = 1'b0;
               s_rlast  = 1'b0;
               remain--;
            end
            if (!s_rvalid && remain > 0 && $urandom_range(99) < rv_pct) begin
               s_rvalid = 1'b1;
               s_rdata  = {$urandom, $urandom};
               s_rresp  = 2'($urandom_range(3));
               s_rlast  = (remain == 1);
               exp_data.push_back(s_rdata);
            end
         end
         m_rready[0] = ($urandom_range(99) < rdy_pct);
         m_rready[1] = ($urandom_range(99) < rdy_pct);
         s_arready   = ($urandom_range(99) < ardy_pct);
      end
   end

   // Burst-level reference model plus monitor.
   bit          busy = 0, ar_done = 0;
   int          starve = 0, k = 0;
   logic        cur = 1'b0, exp_perr = 1'b0, w;
   logic [AW-1:0] cur_addr = '0;
   logic [7:0]  cur_len = '0;
   logic [1:0]  ev;

   always @(negedge clock) begin
      if (reset) begin
         chk("reset_handshakes", {s_arvalid, m_arready, m_rvalid, s_rready}, 64'd0);
         busy = 0; ar_done = 0; starve = 0; cur = 1'b0; exp_perr = 1'b0;
      end else begin
         chk("gnt", gnt, cur);
         chk("prot_err", prot_err, exp_perr);
         exp_perr = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (m_rvalid[p] && m_rready[p]) begin
               if (exp_data.size() == 0)
                  chk("unexpected_beat", 64'd1, 64'd0);
               else
                  chk("rdata", m_rdata, exp_data.pop_front());
            end
         end
         if (!busy) begin
            chk("idle_handshakes", {s_arvalid, m_arready, m_rvalid, s_rready}, 64'd0);
            if (|m_arvalid) begin
               // Fetch is forced once it has lost SMAX rounds in a row.
               if (m_arvalid[0] && starve == SMAX) w = 1'b0;
               else if (m_arvalid[1])              w = 1'b1;
               else                                w = 1'b0;
               if (w == 1'b0) starve = 0;
               else if (m_arvalid[0] && starve < SMAX) starve++;
               cur      = w;
               cur_addr = w ? m_araddr[AW +: AW] : m_araddr[0 +: AW];
               cur_len  = w ? m_arlen[15:8] : m_arlen[7:0];
               busy     = 1;
               ar_done  = 0;
            end
         end else if (!ar_done) begin
            chk("s_arvalid", s_arvalid, 64'd1);
            chk("s_araddr", s_araddr, cur_addr);
            chk("s_arlen", s_arlen, cur_len);
            chk("s_arsize", s_arsize, 64'd3);
            chk("s_arburst", s_arburst, 64'd1);
            ev = 2'b00; ev[cur] = s_arready;
            chk("m_arready", m_arready, ev);
            chk("m_rvalid_in_addr", m_rvalid, 64'd0);
            if (s_arready) begin
               ar_done = 1;
               k = 0;
            end
         end else begin
            chk("ar_quiet_in_data", {s_arvalid, m_arready}, 64'd0);
            ev = 2'b00; ev[cur] = s_rvalid;
            chk("m_rvalid", m_rvalid, ev);
            chk("s_rready", s_rready, m_rready[cur]);
            chk("r_broadcast", {m_rlast, m_rresp}, {s_rlast, s_rresp});
            if (s_rvalid && m_rready[cur]) begin
               exp_perr = (s_rlast != (k == int'(cur_len)));
               k++;
               if (s_rlast) busy = 0;
            end
         end
      end
   end

   task automatic drain(input int limit);
      int n = 0;
      while ((rq[0].size() > 0 || rq[1].size() > 0 || busy) && n < limit) begin
         @(posedge clock);
         n++;
      end
      if (n >= limit) chk("drain_timeout", 64'd1, 64'd0);
      repeat (3) @(posedge clock);
      #2;
   endtask

   int p0;
   logic sg [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      rq[0].push_back('{addr: 32'h3000_0000, len: 8'd3});
      drain(200);

      dut_grants.delete();
      rq[0].push_back('{addr: 32'h3000_0040, len: 8'd1});
      rq[1].push_back('{addr: 32'h8000_0010, len: 8'd0});
      drain(200);
      chk("simul_count", dut_grants.size(), 64'd2);
      if (dut_grants.size() == 2)
         chk("simul_order", {dut_grants[0], dut_grants[1]}, 64'b10);

      dut_grants.delete();
      for (int i = 0; i < 6; i++)
         rq[1].push_back('{addr: 32'h8000_1000 + 32'(i * 8), len: 8'd1});
      rq[0].push_back('{addr: 32'h3000_0080, len: 8'd1});
      drain(500);
      chk("starve_count", dut_grants.size(), 64'd7);
      for (int i = 0; i < 7 && i < dut_grants.size(); i++)
         chk("starve_order", dut_grants[i], sg[i]);

      rdy_pct = 40; rv_pct = 70;
      rq[0].push_back('{addr: 32'h3000_00c0, len: 8'd7});
      drain(500);
      rdy_pct = 100; rv_pct = 100;

      p0 = perr_cnt;
      force_beats = 3;
      rq[0].push_back('{addr: 32'h3000_0100, len: 8'd3});
      drain(200);
      force_beats = 0;
      chk("prot_err_pulses", perr_cnt - p0, 64'd1);

      rq[1].push_back('{addr: 32'h8000_0200, len: 8'd3});
      begin
         int n = 0;
         do begin
            @(negedge clock); #1;
            n++;
         end while (!(busy && ar_done && k == 1) && n < 200);
         if (n >= 200) chk("reset_wait_timeout", 64'd1, 64'd0);
      end
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      #1;
      dut_grants.delete();
      rq[0].push_back('{addr: 32'h3000_0200, len: 8'd1});
      drain(200);
      chk("post_reset_grants", dut_grants.size(), 64'd1);

      gap_pct = 30; rdy_pct = 75; ardy_pct = 70; rv_pct = 75; err_pct = 15;
      for (int i = 0; i < 40; i++) begin
         rq[0].push_back('{addr: $urandom & 32'hFFFF_FFC0,
                           len: 8'($urandom_range(7))});
         rq[1].push_back('{addr: $urandom, len: 8'($urandom_range(7))});
      end
      drain(20000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
